// File: rtl/noise63_checker.sv
// Receive-side checker for the 63-bit (x^63 + x^62 + 1) noise LFSR tap.
// Rebuilds the source state from four samples, then predicts and compares every following sample.
module noise63_checker #(
   parameter int LOCK_THRESH = 2,
   parameter int LOSS_THRESH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [17:0] in,
   input  logic        clr_cnt,
   output logic        locked,
   output logic        match,
   output logic        err,
   output logic        ovr,
   output logic [15:0] err_cnt
);
   // state | meaning
   // ACQ   | loading four consecutive samples into the shadow register
   // ADV   | shifting the shadow 18 times to form the next prediction
   // CHECK | waiting for a sample to compare against sh[17:0]
   typedef enum logic [1:0] {S_ACQ, S_ADV, S_CHECK} state_t;

   localparam int MW = $clog2(LOCK_THRESH + 1);
   localparam int EW = $clog2(LOSS_THRESH + 1);
   localparam logic [MW-1:0] MLIM = MW'(LOCK_THRESH);
   localparam logic [EW-1:0] ELIM = EW'(LOSS_THRESH);

   state_t        state_q, state_d;
   logic [62:0]   sh_q, sh_d;
   logic [1:0]    acq_q, acq_d;
   logic [4:0]    adv_q, adv_d;
   logic [MW-1:0] mcnt_q, mcnt_d;
   logic [EW-1:0] ecnt_q, ecnt_d;
   logic          locked_q, locked_d;
   logic          match_q, match_d;
   logic          err_q, err_d;
   logic          ovr_q, ovr_d;
   logic [15:0]   err_cnt_q, err_cnt_d;

   logic [62:0]   sh_load;
   logic [62:0]   sh_step;
   logic          sample_ok;
   logic [MW-1:0] mcnt_inc;
   logic [EW-1:0] ecnt_inc;

   assign sh_load   = {sh_q[44:0], in};
   assign sh_step   = {sh_q[61:0], sh_q[62] ^ sh_q[61]};
   assign sample_ok = (in == sh_q[17:0]);
   assign mcnt_inc  = (mcnt_q == MLIM) ? mcnt_q : mcnt_q + 1'b1;
   assign ecnt_inc  = ecnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_ACQ;
         sh_q      <= '0;
         acq_q     <= '0;
         adv_q     <= '0;
         mcnt_q    <= '0;
         ecnt_q    <= '0;
         locked_q  <= 1'b0;
         match_q   <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         acq_q     <= acq_d;
         adv_q     <= adv_d;
         mcnt_q    <= mcnt_d;
         ecnt_q    <= ecnt_d;
         locked_q  <= locked_d;
         match_q   <= match_d;
         err_q     <= err_d;
         ovr_q     <= ovr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      acq_d     = acq_q;
      adv_d     = adv_q;
      mcnt_d    = mcnt_q;
      ecnt_d    = ecnt_q;
      locked_d  = locked_q;
      match_d   = 1'b0;
      err_d     = 1'b0;
      ovr_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      case (state_q)
         S_ACQ: begin
            if (ena) begin
               sh_d = sh_load;
               if (acq_q == 2'd3) begin
                  acq_d = 2'd0;
                  // An all-zero load is the LFSR lock-up state; keep collecting.
                  if (sh_load != 63'd0) begin
                     state_d = S_ADV;
                     adv_d   = 5'd17;
                  end
               end else begin
                  acq_d = acq_q + 2'd1;
               end
            end
         end

         S_ADV: begin
            sh_d = sh_step;
            ovr_d = ena;
            if (adv_q == 5'd0) begin
               state_d = S_CHECK;
            end else begin
               adv_d = adv_q - 5'd1;
            end
         end

         S_CHECK: begin
            if (ena) begin
               if (sample_ok) begin
                  match_d = 1'b1;
                  mcnt_d  = mcnt_inc;
                  ecnt_d  = '0;
                  if (mcnt_inc == MLIM) begin
                     locked_d = 1'b1;
                  end
                  state_d = S_ADV;
                  adv_d   = 5'd17;
               end else begin
                  err_d  = 1'b1;
                  mcnt_d = '0;
                  if (locked_q && (ecnt_inc != ELIM)) begin
                     // Free-wheel through isolated errors while locked.
                     ecnt_d  = ecnt_inc;
                     state_d = S_ADV;
                     adv_d   = 5'd17;
                  end else begin
                     locked_d = 1'b0;
                     ecnt_d   = '0;
                     acq_d    = 2'd0;
                     state_d  = S_ACQ;
                  end
               end
            end
         end

         default: begin
            state_d = S_ACQ;
            acq_d   = 2'd0;
         end
      endcase

      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (err_d && locked_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   assign locked  = locked_q;
   assign match   = match_q;
   assign err     = err_q;
   assign ovr     = ovr_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_noise63_checker.sv
// Randomised and directed bench for noise63_checker against an event-level model
// that tracks acquisition, prediction readiness time and lock bookkeeping.
module tb_noise63_checker;
   localparam int LOCK_THRESH = 2;
   localparam int LOSS_THRESH = 3;
   localparam logic [62:0] SEED = 63'h45405AD3851A8944;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic        clr_cnt = 1'b0;
   logic [17:0] in = '0;
   logic        locked, match, err, ovr;
   logic [15:0] err_cnt;

   int checks = 0;
   int failures = 0;
   int n_match = 0, n_err = 0, n_ovr = 0;

   noise63_checker #(.LOCK_THRESH(LOCK_THRESH), .LOSS_THRESH(LOSS_THRESH)) dut (
      .clk(clk), .rst(rst), .ena(ena), .in(in), .clr_cnt(clr_cnt),
      .locked(locked), .match(match), .err(err), .ovr(ovr), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [62:0] adv18(input logic [62:0] s);
      logic [62:0] r;
      r = s;
      for (int i = 0; i < 18; i++) r = {r[61:0], r[62] ^ r[61]};
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_locked = 0, m_match = 0, m_err = 0, m_ovr = 0;
   logic [15:0] m_err_cnt = 0;
   logic [62:0] m_state = 0;
   logic [17:0] m_acq [4];
   int          m_nacq = 0, m_mrun = 0, m_erun = 0;
   bit          m_tracking = 0;
   longint      cyc = 0, m_ready = 0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_locked = 0; m_match = 0; m_err = 0; m_ovr = 0; m_err_cnt = 0;
         m_nacq = 0; m_mrun = 0; m_erun = 0; m_tracking = 0;
         cyc = 0; m_ready = 0; m_state = 0;
      end else begin
         logic was_locked;
         logic [62:0] st;
         was_locked = m_locked;
         cyc++;
         m_match = 0; m_err = 0; m_ovr = 0;
         if (ena) begin
            if (cyc < m_ready) begin
               m_ovr = 1;
            end else if (!m_tracking) begin
               m_acq[m_nacq] = in;
               m_nacq++;
               if (m_nacq == 4) begin
                  m_nacq = 0;
                  st = {m_acq[0][8:0], m_acq[1], m_acq[2], m_acq[3]};
                  if (st != 0) begin
                     m_state = adv18(st);
                     m_tracking = 1;
                     m_ready = cyc + 19;
                  end
               end
            end else if (in == m_state[17:0]) begin
               m_match = 1;
               m_erun = 0;
               if (m_mrun < LOCK_THRESH) m_mrun++;
               if (m_mrun == LOCK_THRESH) m_locked = 1;
               m_state = adv18(m_state);
               m_ready = cyc + 19;
            end else begin
               m_err = 1;
               m_mrun = 0;
               if (m_locked && m_erun + 1 < LOSS_THRESH) begin
                  m_erun++;
                  m_state = adv18(m_state);
                  m_ready = cyc + 19;
               end else begin
                  m_locked = 0; m_erun = 0; m_nacq = 0;
                  m_tracking = 0; m_ready = 0;
               end
            end
         end
         if (clr_cnt) m_err_cnt = 0;
         else if (m_err && was_locked && m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("locked", 64'(locked), 64'(m_locked));
         check("match", 64'(match), 64'(m_match));
         check("err", 64'(err), 64'(m_err));
         check("ovr", 64'(ovr), 64'(m_ovr));
         check("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
         n_match += int'(match);
         n_err   += int'(err);
         n_ovr   += int'(ovr);
      end
   end

   // ---------------- stimulus ----------------
   logic [62:0] src;

   task automatic next_src(output logic [17:0] v);
      src = adv18(src);
      v = src[17:0];
   endtask

   // Called just after a negedge; ena period equals gap.
   task automatic send(input logic [17:0] v, input int gap, input bit clr);
      ena = 1'b1; in = v; clr_cnt = clr;
      @(negedge clk);
      ena = 1'b0; clr_cnt = 1'b0; in = 18'($urandom);
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic send_clean(input int n);
      logic [17:0] s;
      for (int i = 0; i < n; i++) begin
         next_src(s);
         send(s, 20, 1'b0);
      end
   endtask

   initial begin
      #5_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [17:0] s;
      int b0, b1, b2;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_locked", 64'(locked), 64'(0));
      check("rst_pulses", 64'({match, err, ovr}), 64'(0));
      check("rst_err_cnt", 64'(err_cnt), 64'(0));
      check("model_adv18_bit0", 64'(adv18(63'h1)), 64'h40000);
      check("model_adv18_bit62", 64'(adv18(63'h4000_0000_0000_0000)), 64'h20000);
      check("model_adv18_bit62_61", 64'(adv18(63'h6000_0000_0000_0000)), 64'h10000);
      rst = 1'b0;
      @(negedge clk);

      // clean acquisition and lock
      src = SEED;
      send_clean(10);
      check("s1_matches", 64'(n_match), 64'(6));
      check("s1_errs", 64'(n_err), 64'(0));
      check("s1_ovr", 64'(n_ovr), 64'(0));
      check("s1_locked", 64'(locked), 64'(1));

      // single flipped bit
      b0 = n_err;
      next_src(s);
      send(s ^ 18'h00008, 20, 1'b0);
      send_clean(3);
      check("s2_err_pulses", 64'(n_err - b0), 64'(1));
      check("s2_err_cnt", 64'(err_cnt), 64'(1));
      check("s2_locked", 64'(locked), 64'(1));

      // three bad samples drop lock
      for (int i = 0; i < 3; i++) begin
         next_src(s);
         send(18'h3FFFF, 20, 1'b0);
      end
      check("s3_err_cnt", 64'(err_cnt), 64'(4));
      check("s3_unlocked", 64'(locked), 64'(0));
      send_clean(5);
      check("s3_relock_pending", 64'(locked), 64'(0));
      send_clean(1);
      check("s3_relocked", 64'(locked), 64'(1));

      // extra enable during ADV
      b0 = n_ovr; b1 = n_err;
      next_src(s);
      send(s, 5, 1'b0);
      next_src(s);
      send(s, 15, 1'b0);
      send_clean(6);
      check("s5_ovr", 64'(n_ovr - b0), 64'(1));
      check("s5_errs", 64'(n_err - b1), 64'(3));
      check("s5_unlocked", 64'(locked), 64'(0));
      send_clean(3);
      check("s5_relocked", 64'(locked), 64'(1));
      check("s5_err_cnt", 64'(err_cnt), 64'(7));

      // clear wins over simultaneous increment
      next_src(s);
      send(s ^ 18'h00001, 20, 1'b1);
      check("s6_clr_err_cnt", 64'(err_cnt), 64'(0));
      check("s6_locked", 64'(locked), 64'(1));
      send_clean(2);
      next_src(s);
      send(s ^ 18'h00002, 20, 1'b0);
      check("s6_err_cnt_one", 64'(err_cnt), 64'(1));

      // reset in the middle of ADV
      next_src(s);
      send(s, 5, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("s6_rst_locked", 64'(locked), 64'(0));
      check("s6_rst_pulses", 64'({match, err, ovr}), 64'(0));
      check("s6_rst_err_cnt", 64'(err_cnt), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // all-zero acquisition is rejected
      b0 = n_match; b1 = n_err; b2 = n_ovr;
      for (int i = 0; i < 4; i++) send(18'h00000, 20, 1'b0);
      check("s4_zero_pulses", 64'((n_match - b0) + (n_err - b1) + (n_ovr - b2)), 64'(0));
      send_clean(6);
      check("s4_locked", 64'(locked), 64'(1));

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         int gap, r;
         bit clr;
         gap = ($urandom_range(7, 0) == 0) ? int'($urandom_range(18, 3)) : int'($urandom_range(26, 19));
         next_src(s);
         r = int'($urandom_range(19, 0));
         if (r == 0) s[$urandom_range(17, 0)] ^= 1'b1;
         else if (r == 1) s = 18'($urandom);
         else if (r == 2) s = 18'h00000;
         if ($urandom_range(59, 0) == 0) begin
            src = 63'({$urandom, $urandom});
            if (src == 63'd0) src = 63'd1;
         end
         clr = ($urandom_range(15, 0) == 0);
         send(s, gap, clr);
      end
      repeat (30) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noise63_checker.md
# noise63_checker

Receive-side companion to the 63-bit LFSR noise source (x^63 + x^62 + 1, 18 bits advanced per enable). It watches the raw 18-bit LFSR tap, self-synchronises a shadow LFSR from four consecutive samples, and predicts each following sample. It reports lock, per-sample match/mismatch pulses, overruns and a saturating error count. It sits in the synth test/diagnostic path to verify noise-source integrity and enable timing.

## Interface
- LOCK_THRESH, default 2: consecutive matches in CHECK needed to assert `locked`.
- LOSS_THRESH, default 3: consecutive mismatches while locked before re-acquisition.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  sample strobe, one cycle per sample.
- in  in  18  raw LFSR tap sampled on `ena`; bit 0 is the newest bit.
- clr_cnt  in  1  synchronous clear of `err_cnt`.
- locked  out  1  level; high while tracking is confirmed.
- match  out  1  one-cycle pulse: compared sample equalled the prediction.
- err  out  1  one-cycle pulse: compared sample differed from the prediction.
- ovr  out  1  one-cycle pulse: `ena` arrived while the shadow register was advancing.
- err_cnt  out  16  saturating count of mismatches while `locked`.

## Operation
- Shadow register `sh[62:0]`. Shift rule matches the source: `sh <= {sh[61:0], sh[62]^sh[61]}`.
- States:
  - ACQ: each `ena` does `sh <= {sh[44:0], in}` and increments `acq_cnt` (0..3). On the 4th load, `sh = {s0[8:0], s1, s2, s3}`.
    - If the loaded value is all-zero (illegal LFSR state), clear `acq_cnt` and stay in ACQ.
    - Otherwise go to ADV.
  - ADV: one shift per clk for exactly 18 clocks, using `adv_cnt` counting 17 down to 0. After the 0 count, go to CHECK. `sh[17:0]` now holds the predicted next sample.
  - CHECK: wait for `ena`. On `ena`, compare `in` with `sh[17:0]`, then always go to ADV. The shadow free-wheels on a mismatch, so isolated errors do not desync it.
- Match/lock counters:
  - `mcnt`: consecutive matches, saturates at LOCK_THRESH.
  - `ecnt`: consecutive mismatches. Each counter clears the other.
  - `locked` sets when `mcnt` reaches LOCK_THRESH.
- Loss of lock: while `locked`, a mismatch that brings `ecnt` to LOSS_THRESH clears `locked`, `mcnt`, `ecnt` and `acq_cnt`, and returns to ACQ. That sample is not reloaded.
- Unlocked mismatches: while not locked, any mismatch in CHECK returns to ACQ with `acq_cnt` = 0 and `mcnt` = 0. The sample is not reloaded.
- `err_cnt`:
  - Increments on each `err` while `locked` is high in the cycle the compare is made. This includes the mismatch that drops lock.
  - Saturates at 16'hFFFF.
  - `clr_cnt` wins over a simultaneous increment.
- `ena` in ADV:
  - The sample is ignored: no compare and no load.
  - `ovr` pulses.
  - The ADV sequence continues unaffected.
- `ena` in ACQ or CHECK never sets `ovr`.
- Reset values: state ACQ, `sh` = 0, all counters 0, and `locked`/`match`/`err`/`ovr` = 0, `err_cnt` = 0. Reset mid-ADV abandons the shift immediately.

## Timing
- `ena` sampled at edge t in CHECK: `match` or `err` is high in cycle t+1. ADV shifts occur on edges t+1..t+18. CHECK is entered at edge t+18, and the next compare is accepted from edge t+19.
- Minimum `ena` spacing is 19 clocks. This is the same constraint as the source, so a source enable period of 19 or more is always overrun-free.
- 4th ACQ `ena` at edge t: ADV on edges t+1..t+18; the first compare is possible at edge t+19 or later.
- `locked` rises in the same cycle as the LOCK_THRESH-th `match` pulse. It falls in the same cycle as the LOSS_THRESH-th `err` pulse.
- `err_cnt` updates in the same cycle as `err`.
- `ovr` is high in the cycle after the offending `ena` edge.

## Test plan
- Bench reference LFSR seeded 63'h45405AD3851A8944, `ena` every 20 clocks, 10 samples: no pulses during 4 ACQ samples → `match` on samples 5 and 6, `locked` = 1 with sample 6's match, samples 7–10 match, `err_cnt` = 0, `ovr` never asserted.
- Locked stream, sample 8 with bit 3 flipped → single `err` pulse, `err_cnt` = 1, `locked` stays 1; samples 9+ return to `match`.
- Locked stream, three consecutive samples replaced by 18'h3FFFF → 3 `err` pulses, `err_cnt` = 3, `locked` falls with the 3rd pulse. The next 4 clean samples reacquire and lock is regained after 2 further matches.
- Four `ena` with `in` = 18'h00000 → stays in ACQ, no `match`/`err`/`ovr`. A following clean stream then locks normally.
- Locked, extra `ena` issued 5 clocks after a compare → `ovr` pulses once with no `err`. The following correctly-timed sample is predicted against, and the next source sample mismatches as a consequence (skip-one desync) → `err`.
- `rst` asserted mid-ADV and `clr_cnt` asserted together with an `err` at `err_cnt` = 16'hFFFF → outputs and counters are zero immediately on `rst`; `clr_cnt` leaves `err_cnt` = 0.
